// File: rtl/declick_gain_stage.sv
// declick_gain_stage
// Captures the mixed voice stream once per I2S frame (ws falling edge), applies
// a linear fade-in/fade-out gain ramp driven by the "any voice on" / forced-mute
// condition, and presents a gained sample that stays stable for the whole frame.
module declick_gain_stage #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int GAIN_WIDTH   = 8,
    parameter int RAMP_STEP    = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    ws_in,
    input  logic [SAMPLE_WIDTH-1:0] stream_in,
    input  logic                    any_on_in,
    input  logic                    force_mute_in,
    output logic [SAMPLE_WIDTH-1:0] stream_out,
    output logic                    sample_valid_out,
    output logic [GAIN_WIDTH:0]     gain_out,
    output logic                    muted_out
);

    // Product of a signed sample and a zero-extended unsigned gain.
    localparam int PW = SAMPLE_WIDTH + GAIN_WIDTH + 2;
    // Gain arithmetic width: one guard bit above the gain register so sums never wrap.
    localparam int AW = GAIN_WIDTH + 2;

    localparam logic [AW-1:0] UNITY = {2'b01, {GAIN_WIDTH{1'b0}}};
    localparam logic [AW-1:0] STEP  = AW'(RAMP_STEP);

    typedef enum logic [1:0] {
        S_MUTED     = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_OPEN      = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t                   r_state;
    logic [GAIN_WIDTH:0]      r_gain;
    logic                     r_muted;

    logic                     r_ws_prev;
    logic [SAMPLE_WIDTH-1:0]  r_sample;
    logic [GAIN_WIDTH:0]      r_gain_lat;
    logic                     r_s1_valid;
    logic signed [PW-1:0]     r_product;
    logic                     r_s2_valid;

    logic                     w_tick;
    logic                     w_mute_req;
    logic [AW-1:0]            w_gain_ext;
    logic [AW-1:0]            w_gain_sum;
    logic [AW-1:0]            w_gain_up;
    logic [AW-1:0]            w_gain_dn;
    logic signed [PW-1:0]     w_sample_sext;
    logic signed [PW-1:0]     w_gain_zext;
    logic signed [PW-1:0]     w_product;
    logic                     w_unused_product_bits;

    assign w_tick     = r_ws_prev & ~ws_in;
    assign w_mute_req = force_mute_in | ~any_on_in;

    // Clamped ramp arithmetic: up saturates at unity, down saturates at zero.
    assign w_gain_ext = {1'b0, r_gain};
    assign w_gain_sum = w_gain_ext + STEP;
    assign w_gain_up  = (w_gain_sum >= UNITY) ? UNITY : w_gain_sum;
    assign w_gain_dn  = (w_gain_ext <= STEP) ? '0 : (w_gain_ext - STEP);

    // Full-width signed multiply; gain is non-negative so it is zero-extended.
    assign w_sample_sext = {{(PW-SAMPLE_WIDTH){r_sample[SAMPLE_WIDTH-1]}}, r_sample};
    assign w_gain_zext   = {{(PW-GAIN_WIDTH-1){1'b0}}, r_gain_lat};
    assign w_product     = w_sample_sext * w_gain_zext;

    // Arithmetic shift right by GAIN_WIDTH, keeping the sample-width slice.
    // The product never exceeds the sample range because gain <= unity.
    assign stream_out       = r_product[GAIN_WIDTH +: SAMPLE_WIDTH];
    assign sample_valid_out = r_s2_valid;
    assign gain_out         = r_gain;
    assign muted_out        = r_muted;

    // Fraction and sign-extension bits of the product are not needed downstream.
    assign w_unused_product_bits = ^{r_product[PW-1:GAIN_WIDTH+SAMPLE_WIDTH],
                                     r_product[GAIN_WIDTH-1:0]};

    // Frame-tick edge detect and stage 1: capture sample and pre-update gain.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ws_prev  <= 1'b1;
            r_sample   <= '0;
            r_gain_lat <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_ws_prev  <= ws_in;
            r_s1_valid <= w_tick;
            if (w_tick) begin
                r_sample   <= stream_in;
                r_gain_lat <= r_gain;
            end
        end
    end

    // Stage 2: register the product; it holds until the next captured frame.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_product  <= '0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_product <= w_product;
            end
        end
    end

    // Gain-ramp FSM, advanced only on frame ticks; reversal keeps the current gain.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_MUTED;
            r_gain  <= '0;
            r_muted <= 1'b1;
        end else if (w_tick) begin
            case (r_state)
                S_MUTED: begin
                    if (!w_mute_req) begin
                        r_state <= S_RAMP_UP;
                        r_muted <= 1'b0;
                    end
                end
                S_RAMP_UP: begin
                    if (w_mute_req) begin
                        r_state <= S_RAMP_DOWN;
                    end else begin
                        r_gain <= w_gain_up[GAIN_WIDTH:0];
                        if (w_gain_up == UNITY) begin
                            r_state <= S_OPEN;
                        end
                    end
                end
                S_OPEN: begin
                    if (w_mute_req) begin
                        r_state <= S_RAMP_DOWN;
                    end
                end
                S_RAMP_DOWN: begin
                    if (!w_mute_req) begin
                        r_state <= S_RAMP_UP;
                    end else begin
                        r_gain <= w_gain_dn[GAIN_WIDTH:0];
                        if (w_gain_dn == '0) begin
                            r_state <= S_MUTED;
                            r_muted <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_MUTED;
                    r_gain  <= '0;
                    r_muted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_declick_gain_stage.sv
// Directed testbench for declick_gain_stage: frame-by-frame stimulus with
// hand-computed gain, mute flag and gained-sample expectations.
module tb_declick_gain_stage;

    logic        clk_in;
    logic        rst_n_in;
    logic        ws_in;
    logic [15:0] stream_in;
    logic        any_on_in;
    logic        force_mute_in;
    logic [15:0] stream_out;
    logic        sample_valid_out;
    logic [8:0]  gain_out;
    logic        muted_out;

    int checks = 0;
    int errors = 0;

    declick_gain_stage #(
        .SAMPLE_WIDTH (16),
        .GAIN_WIDTH   (8),
        .RAMP_STEP    (16)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .ws_in            (ws_in),
        .stream_in        (stream_in),
        .any_on_in        (any_on_in),
        .force_mute_in    (force_mute_in),
        .stream_out       (stream_out),
        .sample_valid_out (sample_valid_out),
        .gain_out         (gain_out),
        .muted_out        (muted_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One I2S frame: ws high for a few cycles, then the falling edge (tick).
    // Called and returns at #1 after a rising edge.
    task automatic frame(input string tag, input logic [15:0] smp, input logic on,
                         input logic fm, input logic [15:0] exp_out,
                         input logic [8:0] exp_gain, input logic exp_muted);
        logic [15:0] held;
        ws_in         = 1'b1;
        stream_in     = smp;
        any_on_in     = on;
        force_mute_in = fm;
        repeat (3) @(posedge clk_in);
        #1;
        ws_in = 1'b0;                               // cycle T
        chk({tag, " valid@T"}, 32'(sample_valid_out), 32'd0);
        @(posedge clk_in); #1;                      // cycle T+1
        chk({tag, " gain"}, 32'(gain_out), 32'(exp_gain));
        chk({tag, " muted"}, 32'(muted_out), 32'(exp_muted));
        chk({tag, " valid@T+1"}, 32'(sample_valid_out), 32'd0);
        stream_in = 16'h5A5A;                       // off-tick changes must be ignored
        any_on_in = ~on;
        @(posedge clk_in); #1;                      // cycle T+2
        chk({tag, " valid@T+2"}, 32'(sample_valid_out), 32'd1);
        chk({tag, " out"}, 32'(stream_out), 32'(exp_out));
        held = exp_out;
        @(posedge clk_in); #1;                      // cycle T+3
        chk({tag, " valid@T+3"}, 32'(sample_valid_out), 32'd0);
        chk({tag, " hold"}, 32'(stream_out), 32'(held));
        $display("frame %s: in=%h gain=%0d muted=%0d out=%h", tag, smp, gain_out, muted_out, stream_out);
    endtask

    initial begin
        rst_n_in      = 1'b0;
        ws_in         = 1'b1;
        stream_in     = 16'h0000;
        any_on_in     = 1'b0;
        force_mute_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset out", 32'(stream_out), 32'd0);
        chk("reset valid", 32'(sample_valid_out), 32'd0);
        chk("reset gain", 32'(gain_out), 32'd0);
        chk("reset muted", 32'(muted_out), 32'd1);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        chk("post-release valid", 32'(sample_valid_out), 32'd0);

        // 1: voices off, stays muted
        for (int i = 0; i < 5; i++)
            frame("t1 muted", 16'h4000, 1'b0, 1'b0, 16'h0000, 9'd0, 1'b1);

        // 2: voices on, MUTED -> RAMP_UP without gain change, then 16 ramp steps
        frame("t2 start", 16'h4000, 1'b1, 1'b0, 16'h0000, 9'd0, 1'b0);
        for (int k = 1; k <= 16; k++)
            frame("t2 up", 16'h4000, 1'b1, 1'b0, 16'((k - 1) * 16'h0400), 9'(16 * k), 1'b0);
        frame("t2 unity", 16'h4000, 1'b1, 1'b0, 16'h4000, 9'd256, 1'b0);
        frame("t2 minneg", 16'h8000, 1'b1, 1'b0, 16'h8000, 9'd256, 1'b0);

        // 3: voices off from OPEN: hold, then 240..0; -1 at gain 16 stays -1
        frame("t3 turn", 16'h4000, 1'b0, 1'b0, 16'h4000, 9'd256, 1'b0);
        for (int k = 1; k <= 15; k++)
            frame("t3 down", 16'h4000, 1'b0, 1'b0, 16'(64 * (256 - 16 * (k - 1))), 9'(256 - 16 * k), 1'b0);
        frame("t3 neg1", 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 9'd0, 1'b1);
        frame("t3 zero", 16'hFFFF, 1'b0, 1'b0, 16'h0000, 9'd0, 1'b1);

        // 4: reversal mid-ramp at 128 (down) and at 64 (up)
        frame("t4 start", 16'h4000, 1'b1, 1'b0, 16'h0000, 9'd0, 1'b0);
        for (int k = 1; k <= 8; k++)
            frame("t4 up", 16'h4000, 1'b1, 1'b0, 16'(64 * 16 * (k - 1)), 9'(16 * k), 1'b0);
        frame("t4 rev down", 16'h4000, 1'b0, 1'b0, 16'h2000, 9'd128, 1'b0);
        for (int k = 1; k <= 4; k++)
            frame("t4 down", 16'h4000, 1'b0, 1'b0, 16'(64 * (128 - 16 * (k - 1))), 9'(128 - 16 * k), 1'b0);
        frame("t4 rev up", 16'h4000, 1'b1, 1'b0, 16'h1000, 9'd64, 1'b0);
        for (int k = 1; k <= 12; k++)
            frame("t4 up2", 16'h4000, 1'b1, 1'b0, 16'(64 * (64 + 16 * (k - 1))), 9'(64 + 16 * k), 1'b0);

        // 5: forced mute with voices on
        frame("t5 turn", 16'h4000, 1'b1, 1'b1, 16'h4000, 9'd256, 1'b0);
        for (int k = 1; k <= 16; k++)
            frame("t5 down", 16'h4000, 1'b1, 1'b1, 16'(64 * (256 - 16 * (k - 1))), 9'(256 - 16 * k), k == 16);
        frame("t5 stay", 16'h4000, 1'b1, 1'b1, 16'h0000, 9'd0, 1'b1);
        frame("t5 stay", 16'h4000, 1'b1, 1'b1, 16'h0000, 9'd0, 1'b1);
        frame("t5 release", 16'h4000, 1'b1, 1'b0, 16'h0000, 9'd0, 1'b0);

        // 6: async reset between T and T+2
        frame("t6 up", 16'h4000, 1'b1, 1'b0, 16'h0000, 9'd16, 1'b0);
        frame("t6 up", 16'h4000, 1'b1, 1'b0, 16'h0400, 9'd32, 1'b0);
        ws_in     = 1'b1;
        stream_in = 16'h4000;
        any_on_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        ws_in = 1'b0;                               // cycle T
        @(posedge clk_in); #1;                      // cycle T+1
        rst_n_in = 1'b0;
        #1;
        chk("t6 rst out", 32'(stream_out), 32'd0);
        chk("t6 rst valid", 32'(sample_valid_out), 32'd0);
        chk("t6 rst gain", 32'(gain_out), 32'd0);
        chk("t6 rst muted", 32'(muted_out), 32'd1);
        @(posedge clk_in); #1;
        chk("t6 rst valid@T+2", 32'(sample_valid_out), 32'd0);
        ws_in = 1'b1;
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        chk("t6 release valid", 32'(sample_valid_out), 32'd0);
        chk("t6 release muted", 32'(muted_out), 32'd1);
        frame("t6 fresh", 16'h4000, 1'b1, 1'b0, 16'h0000, 9'd0, 1'b0);
        frame("t6 next", 16'h4000, 1'b1, 1'b0, 16'h0000, 9'd16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
